shifter_pipe: RTL and testbench



---
 rtl/shifter_pipe_pkg.sv | 14 +
 rtl/shifter_pipe_stage.sv | 93 +++++++++
 rtl/shifter_pipe.sv | 93 +++++++++
 tb/tb_shifter_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pipe_pkg.sv
// Shared types for the pipelined shifter: operation modes and direction encodings.
package shifter_pkg;

   typedef enum logic [1:0] {
      SH_LOG = 2'b00,
      SH_ARI = 2'b01,
      SH_ROT = 2'b10,
      SH_RSV = 2'b11
   } shift_mode_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shifter_pipe_stage.sv
// One pipeline stage: conditional shift/rotate by 2^K, then a registered payload
// slot that loads when empty or when the downstream slot is advancing.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = 3,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned K     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic [SHW-1:0]   up_shift,
   input  logic             up_dir,
   input  shift_mode_e      up_mode,
   input  logic [TAG_W-1:0] up_tag,
   input  logic             up_spill,
   input  logic             up_illegal,
   input  logic             dn_ready,
   output logic             dn_valid,
   output logic [WIDTH-1:0] dn_data,
   output logic [SHW-1:0]   dn_shift,
   output logic             dn_dir,
   output shift_mode_e      dn_mode,
   output logic [TAG_W-1:0] dn_tag,
   output logic             dn_spill,
   output logic             dn_illegal
);

   localparam int unsigned      S       = 1 << K;
   localparam logic [WIDTH-1:0] ALL1    = '1;
   localparam logic [WIDTH-1:0] LO_MASK = ~(ALL1 << S);
   localparam logic [WIDTH-1:0] HI_MASK = ~(ALL1 >> S);

   logic             load;
   logic [WIDTH-1:0] nxt_data;
   logic             nxt_spill;
   logic             nxt_illegal;

   assign load = !dn_valid || dn_ready;

   // Arithmetic right keeps the current MSB, which is the original sign since
   // earlier stages never alter it in that mode.
   always_comb begin
      nxt_data    = up_data;
      nxt_spill   = up_spill;
      nxt_illegal = up_illegal || (up_mode == SH_RSV);
      if (up_shift[K]) begin
         if (up_mode == SH_ROT) begin
            if (up_dir == DIR_RIGHT)
               nxt_data = (up_data >> S) | (up_data << (WIDTH - S));
            else
               nxt_data = (up_data << S) | (up_data >> (WIDTH - S));
         end else if (up_dir == DIR_RIGHT) begin
            if (up_mode == SH_ARI)
               nxt_data = $signed(up_data) >>> S;
            else
               nxt_data = up_data >> S;
            nxt_spill = up_spill || (|(up_data & LO_MASK));
         end else begin
            nxt_data  = up_data << S;
            nxt_spill = up_spill || (|(up_data & HI_MASK));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_valid   <= 1'b0;
         dn_data    <= '0;
         dn_shift   <= '0;
         dn_dir     <= DIR_LEFT;
         dn_mode    <= SH_LOG;
         dn_tag     <= '0;
         dn_spill   <= 1'b0;
         dn_illegal <= 1'b0;
      end else if (load) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data    <= nxt_data;
            dn_shift   <= up_shift;
            dn_dir     <= up_dir;
            dn_mode    <= up_mode;
            dn_tag     <= up_tag;
            dn_spill   <= nxt_spill;
            dn_illegal <= nxt_illegal;
         end
      end
   end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: one stage per shift-amount bit, valid/ready
// on both sides with bubble collapsing under backpressure.
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned TAG_W = 4,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shift,
   input  logic             in_dir,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_spill,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic             v_w     [SHW+1];
   logic [WIDTH-1:0] data_w  [SHW+1];
   logic [SHW-1:0]   shift_w [SHW+1];
   logic             dir_w   [SHW+1];
   shift_mode_e      mode_w  [SHW+1];
   logic [TAG_W-1:0] tag_w   [SHW+1];
   logic             spill_w [SHW+1];
   logic             ill_w   [SHW+1];
   logic [SHW:0]     rdy;
   logic             unused_ctrl;

   assign v_w[0]     = in_valid;
   assign data_w[0]  = in_data;
   assign shift_w[0] = in_shift;
   assign dir_w[0]   = in_dir;
   assign mode_w[0]  = shift_mode_e'(in_mode);
   assign tag_w[0]   = in_tag;
   assign spill_w[0] = 1'b0;
   assign ill_w[0]   = 1'b0;

   // rdy[k] is the load condition of stage k, rippling back from out_ready.
   always_comb begin
      rdy[SHW] = out_ready;
      for (int unsigned i = 0; i < SHW; i++)
         rdy[SHW-1-i] = !v_w[SHW-i] || rdy[SHW-i];
   end

   assign in_ready = rdy[0];

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      shifter_stage #(
         .WIDTH (WIDTH),
         .SHW   (SHW),
         .TAG_W (TAG_W),
         .K     (k)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid   (v_w[k]),
         .up_data    (data_w[k]),
         .up_shift   (shift_w[k]),
         .up_dir     (dir_w[k]),
         .up_mode    (mode_w[k]),
         .up_tag     (tag_w[k]),
         .up_spill   (spill_w[k]),
         .up_illegal (ill_w[k]),
         .dn_ready   (rdy[k+1]),
         .dn_valid   (v_w[k+1]),
         .dn_data    (data_w[k+1]),
         .dn_shift   (shift_w[k+1]),
         .dn_dir     (dir_w[k+1]),
         .dn_mode    (mode_w[k+1]),
         .dn_tag     (tag_w[k+1]),
         .dn_spill   (spill_w[k+1]),
         .dn_illegal (ill_w[k+1])
      );
   end

   assign out_valid   = v_w[SHW];
   assign out_data    = data_w[SHW];
   assign out_spill   = spill_w[SHW];
   assign out_illegal = ill_w[SHW];
   assign out_tag     = tag_w[SHW];

   assign unused_ctrl = ^{shift_w[SHW], dir_w[SHW], mode_w[SHW]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe (WIDTH=8): directed plan items plus a
// randomized phase scored against a whole-word arithmetic reference model.
module tb_shifter_pipe;

   localparam int W   = 8;
   localparam int SHW = 3;
   localparam int TW  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_data;
   logic [SHW-1:0] in_shift;
   logic          in_dir;
   logic [1:0]    in_mode;
   logic [TW-1:0] in_tag;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_data;
   logic          out_spill, out_illegal;
   logic [TW-1:0] out_tag;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic lat_on = 1'b0;

   typedef struct {
      logic [W-1:0]  d;
      logic          sp;
      logic          il;
      logic [TW-1:0] tag;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];

   shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_shift    (in_shift),
      .in_dir      (in_dir),
      .in_mode     (in_mode),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_spill   (out_spill),
      .out_illegal (out_illegal),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
      end
   endtask

   // Whole-amount reference: shift a double-width word once, read off result and discarded half.
   function automatic exp_t model(input logic [W-1:0] d, input logic [SHW-1:0] s,
                                  input logic dir, input logic [1:0] mode,
                                  input logic [TW-1:0] t, input int c);
      exp_t e;
      logic [2*W-1:0] ext;
      logic [W-1:0]   fill;
      e.tag = t;
      e.cyc = c;
      e.il  = (mode == 2'b11);
      e.sp  = 1'b0;
      if (mode == 2'b10) begin
         ext = {d, d};
         if (dir) begin ext = ext >> s; e.d = ext[W-1:0]; end
         else     begin ext = ext << s; e.d = ext[2*W-1:W]; end
      end else if (!dir) begin
         ext  = {{W{1'b0}}, d} << s;
         e.d  = ext[W-1:0];
         e.sp = |ext[2*W-1:W];
      end else begin
         ext  = {d, {W{1'b0}}} >> s;
         e.d  = ext[2*W-1:W];
         e.sp = |ext[W-1:0];
         if (mode == 2'b01 && d[W-1]) begin
            fill = {W{1'b1}} >> s;
            e.d  = e.d | ~fill;
         end
      end
      return e;
   endfunction

   task automatic drive_rand(input logic [TW-1:0] t);
      in_data  = W'($urandom);
      in_shift = SHW'($urandom);
      in_dir   = 1'($urandom);
      in_mode  = 2'($urandom);
      in_tag   = t;
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   logic          stalled = 1'b0;
   logic [W-1:0]  h_data;
   logic [TW-1:0] h_tag;
   logic [1:0]    h_fl;
   exp_t          m_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(h_data));
            chk("stall_tag", 32'(out_tag), 32'(h_tag));
            chk("stall_flags", 32'({out_spill, out_illegal}), 32'(h_fl));
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in_data, in_shift, in_dir, in_mode, in_tag, cyc));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               m_e = exp_q.pop_front();
               chk("sb_data", 32'(out_data), 32'(m_e.d));
               chk("sb_spill", 32'(out_spill), 32'(m_e.sp));
               chk("sb_illegal", 32'(out_illegal), 32'(m_e.il));
               chk("sb_tag", 32'(out_tag), 32'(m_e.tag));
               if (lat_on) chk("sb_latency", 32'(cyc - m_e.cyc), 32'(SHW));
            end
         end
         stalled = out_valid && !out_ready;
         h_data  = out_data;
         h_tag   = out_tag;
         h_fl    = {out_spill, out_illegal};
      end
   end

   task automatic single(input logic [W-1:0] d, input logic [SHW-1:0] s, input logic dir,
                         input logic [1:0] mode, input logic [TW-1:0] t,
                         input logic [W-1:0] ed, input logic es, input logic ei);
      int n;
      @(posedge clk); #1;
      in_data = d; in_shift = s; in_dir = dir; in_mode = mode; in_tag = t;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("single_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("single_latency", 32'(n), 32'(SHW));
      chk("single_data", 32'(out_data), 32'(ed));
      chk("single_spill", 32'(out_spill), 32'(es));
      chk("single_illegal", 32'(out_illegal), 32'(ei));
      chk("single_tag", 32'(out_tag), 32'(t));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc, tg, n;
      logic got;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_shift = '0; in_dir = 1'b0; in_mode = 2'b00; in_tag = '0;
      #2;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_flags", 32'({out_spill, out_illegal}), 32'd0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b1;

      single(8'b1001_0110, 3'd3, 1'b0, 2'b00, 4'h1, 8'b1011_0000, 1'b1, 1'b0);
      single(8'b1000_0001, 3'd2, 1'b1, 2'b01, 4'h2, 8'b1110_0000, 1'b1, 1'b0);
      single(8'b1000_0001, 3'd1, 1'b1, 2'b10, 4'h3, 8'b1100_0000, 1'b0, 1'b0);
      single(8'h5A,        3'd0, 1'b0, 2'b00, 4'h4, 8'h5A,        1'b0, 1'b0);
      single(8'h81,        3'd1, 1'b0, 2'b11, 4'h5, 8'h02,        1'b1, 1'b1);
      single(8'h81,        3'd7, 1'b0, 2'b10, 4'h6, 8'hC0,        1'b0, 1'b0);

      // Backpressure: six tags streamed while the consumer stalls.
      @(posedge clk); #1;
      out_ready = 1'b0; tg = 0; acc = 0;
      drive_rand(4'(tg)); in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #1;
         if (got) begin acc++; tg++; drive_rand(4'(tg)); end
      end
      chk("bp_accepts", 32'(acc), 32'd3);
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("bp_drain_valid", 32'(out_valid), 32'd1);
         chk("bp_drain_tag", 32'(out_tag), 32'(k));
         got = in_valid && in_ready;
         @(posedge clk); #1;
         if (got) begin
            tg++;
            if (tg < 6) drive_rand(4'(tg));
            else in_valid = 1'b0;
         end
      end

      // Continuous pass-through with an always-ready consumer.
      @(posedge clk); #1;
      lat_on = 1'b1; out_ready = 1'b1;
      drive_rand(4'd0); in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("pt_in_ready", 32'(in_ready), 32'd1);
         if (c >= SHW) chk("pt_out_valid", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
         drive_rand(4'(c + 1));
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 lat_on = 1'b0;

      // Reset with two items in flight, the first already presented at the output.
      out_ready = 1'b0;
      drive_rand(4'hA); in_valid = 1'b1;
      @(posedge clk); #1;
      drive_rand(4'hB);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_flags", 32'({out_spill, out_illegal}), 32'd0);
      chk("mid_rst_tag", 32'(out_tag), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      single(8'h3C, 3'd2, 1'b1, 2'b00, 4'h7, 8'h0F, 1'b0, 1'b0);

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         got = in_valid && in_ready;
         @(posedge clk); #1;
         if (got || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            drive_rand(4'(c));
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
